// File: rtl/mac_pattern_detect.sv
// ---------------------------------------------------------------------------
// mac_pattern_detect
//
// Pipelined unsigned multiply/accumulate with masked pattern and
// inverse-pattern detection, a sticky ACC overflow flag and a saturating
// count of detecting results.
//
// Build option:
//   MAC_PD_AUTORESET_EN  when defined, an ACC issued while the registered
//                        pattern_detect is high accumulates onto zero
//                        instead of onto p (terminal-count style restart).
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   in_valid         qualifies a, b, opmode this cycle
//   a, b             unsigned operands
//   opmode           00 MUL, 01 ACC, 10 CLR, 11 HOLD
//   pattern, mask    compare pattern / ignore-mask, sampled in the result stage
//   out_valid        one-cycle pulse per accepted input
//   p                result register
//   pattern_detect   (p & ~mask) == ( pattern & ~mask)
//   pattern_b_detect (p & ~mask) == (~pattern & ~mask)
//   overflow         sticky ACC carry-out, cleared by CLR or rst
//   detect_count     saturating count of detecting results
//
// Latency: an input captured on edge n updates p and pulses out_valid on
// edge n+3. The product is registered twice so the multiplier can be
// retimed; accumulation feedback stays inside the result stage.
// ---------------------------------------------------------------------------
module mac_pattern_detect #(
  parameter int A_WIDTH   = 11,
  parameter int B_WIDTH   = 11,
  parameter int P_WIDTH   = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [1:0]           opmode,
  input  logic [P_WIDTH-1:0]   pattern,
  input  logic [P_WIDTH-1:0]   mask,
  output logic                 out_valid,
  output logic [P_WIDTH-1:0]   p,
  output logic                 pattern_detect,
  output logic                 pattern_b_detect,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] detect_count
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_ACC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  // Saturating increment of the detect counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Masked equality; a mask bit of 1 removes that bit from the compare.
  function automatic logic masked_match(input logic [P_WIDTH-1:0] v,
                                        input logic [P_WIDTH-1:0] pat,
                                        input logic [P_WIDTH-1:0] msk);
    return ((v ^ pat) & ~msk) == '0;
  endfunction

  logic                 vld_p0_q, vld_p1_q, vld_p2_q;
  logic [A_WIDTH-1:0]   a_p0_q;
  logic [B_WIDTH-1:0]   b_p0_q;
  logic [1:0]           op_p0_q, op_p1_q, op_p2_q;
  logic [M_WIDTH-1:0]   prod_p0;
  logic [P_WIDTH-1:0]   m_p1_q, m_p2_q;

  logic [P_WIDTH-1:0]   p_q, p_d;
  logic [P_WIDTH-1:0]   fb;
  logic [P_WIDTH:0]     sum;
  logic                 det_q, det_d;
  logic                 detb_q, detb_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_valid_q;

  // Valid bits are control and take the reset; a reset also drops in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= in_valid;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  // ---- stage p0 -> p1: operand capture and multiply
  assign prod_p0 = M_WIDTH'(a_p0_q) * M_WIDTH'(b_p0_q);

  always_ff @(posedge clk) begin
    if (in_valid) begin
      a_p0_q  <= a;
      b_p0_q  <= b;
      op_p0_q <= opmode;
    end
    if (vld_p0_q) begin
      m_p1_q  <= P_WIDTH'(prod_p0);
      op_p1_q <= op_p0_q;
    end
    if (vld_p1_q) begin
      m_p2_q  <= m_p1_q;
      op_p2_q <= op_p1_q;
    end
  end

  // ---- stage p2 -> result: opmode apply, detect, flags
  always_comb begin
    fb = p_q;
`ifdef MAC_PD_AUTORESET_EN
    // A detecting result restarts the next accumulation from zero.
    if (det_q) fb = '0;
`endif
    sum   = {1'b0, fb} + {1'b0, m_p2_q};
    p_d   = p_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    case (op_p2_q)
      OP_MUL: p_d = m_p2_q;
      OP_ACC: begin
        p_d = sum[P_WIDTH-1:0];
        if (sum[P_WIDTH]) ovf_d = 1'b1;
      end
      OP_CLR: begin
        p_d   = '0;
        ovf_d = 1'b0;
      end
      OP_HOLD: p_d = p_q;
      default: p_d = p_q;
    endcase
    // Flags are computed on the value being written so they stay aligned with p.
    det_d  = masked_match(p_d, pattern, mask);
    detb_d = masked_match(p_d, ~pattern, mask);
    if (op_p2_q == OP_CLR) begin
      cnt_d = det_d ? CNT_WIDTH'(1) : '0;
    end else if (det_d) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      det_q       <= 1'b0;
      detb_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= vld_p2_q;
      if (vld_p2_q) begin
        p_q    <= p_d;
        det_q  <= det_d;
        detb_q <= detb_d;
        ovf_q  <= ovf_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign p                = p_q;
  assign pattern_detect   = det_q;
  assign pattern_b_detect = detb_q;
  assign overflow         = ovf_q;
  assign detect_count     = cnt_q;

endmodule

// File: tb/tb_mac_pattern_detect.sv
// ---------------------------------------------------------------------------
// tb_mac_pattern_detect
//
// Directed and randomized bench for mac_pattern_detect. A behavioural model
// tracks each accepted operation as a queue entry that matures three edges
// after capture and applies the opmode rules with plain integer arithmetic.
// Every cycle all outputs are compared with the model; directed sections
// additionally compare captured results against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mac_pattern_detect;

  localparam int AW = 11;
  localparam int BW = 11;
  localparam int PW = 24;
  localparam int CW = 8;
  localparam longint PMOD   = 64'd1 << PW;
  localparam longint CNTMAX = (64'd1 << CW) - 1;
`ifdef MAC_PD_AUTORESET_EN
  localparam longint EXP_THIRD = 36;
`else
  localparam longint EXP_THIRD = 108;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic [1:0]    opmode;
  logic [PW-1:0] pattern;
  logic [PW-1:0] mask;
  logic          out_valid;
  logic [PW-1:0] p;
  logic          pattern_detect;
  logic          pattern_b_detect;
  logic          overflow;
  logic [CW-1:0] detect_count;

  always #5 clk = ~clk;

  mac_pattern_detect #(
    .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .opmode(opmode),
    .pattern(pattern), .mask(mask), .out_valid(out_valid), .p(p),
    .pattern_detect(pattern_detect), .pattern_b_detect(pattern_b_detect),
    .overflow(overflow), .detect_count(detect_count)
  );

  typedef struct { int due; logic [1:0] op; longint prod; } op_t;
  typedef struct { int cyc; longint p; logic pd; logic pbd; logic ovf; longint cnt; } res_t;

  op_t    pend[$];
  res_t   got[$];
  longint m_p;
  bit     m_pd, m_pbd, m_ovf, m_ov;
  longint m_cnt;
  int     cyc;
  int     n_chk;
  int     n_fail;
  int     lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic bit det(input longint v, input longint pat, input longint msk);
    longint keep;
    keep = ~msk & (PMOD - 1);
    return (v & keep) == (pat & keep);
  endfunction

  function automatic bit detb(input longint v, input longint pat, input longint msk);
    longint keep;
    keep = ~msk & (PMOD - 1);
    return (v & keep) == (~pat & keep);
  endfunction

  task automatic model_apply(input logic [1:0] op, input longint prod,
                             input longint pat, input longint msk);
    longint base;
    bit     restart;
    restart = 1'b0;
`ifdef MAC_PD_AUTORESET_EN
    restart = m_pd;
`endif
    case (op)
      2'b00: m_p = prod;
      2'b01: begin
        base = restart ? 0 : m_p;
        m_p  = base + prod;
        if (m_p >= PMOD) begin
          m_p   = m_p - PMOD;
          m_ovf = 1'b1;
        end
      end
      2'b10: begin
        m_p   = 0;
        m_ovf = 1'b0;
      end
      default: ;
    endcase
    m_pd  = det(m_p, pat, msk);
    m_pbd = detb(m_p, pat, msk);
    if (op == 2'b10) m_cnt = m_pd ? 1 : 0;
    else if (m_pd && m_cnt < CNTMAX) m_cnt = m_cnt + 1;
  endtask

  // One clock: model the edge from the inputs presented before it, then
  // compare every output just after the edge.
  task automatic tick();
    bit         r;
    bit         iv;
    logic [1:0] op;
    longint     pr;
    longint     pat;
    longint     msk;
    op_t        o;
    res_t       g;
    r   = rst;
    iv  = in_valid;
    op  = opmode;
    pr  = longint'(a) * longint'(b);
    pat = longint'(pattern);
    msk = longint'(mask);
    @(posedge clk);
    cyc++;
    if (r) begin
      pend.delete();
      m_p = 0; m_pd = 0; m_pbd = 0; m_ovf = 0; m_ov = 0; m_cnt = 0;
    end else begin
      m_ov = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        o = pend.pop_front();
        model_apply(o.op, o.prod, pat, msk);
        m_ov = 1'b1;
      end
      if (iv) begin
        o.due  = cyc + 3;
        o.op   = op;
        o.prod = pr;
        pend.push_back(o);
      end
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("p", 64'(p), m_p);
    check("pattern_detect", 64'(pattern_detect), 64'(m_pd));
    check("pattern_b_detect", 64'(pattern_b_detect), 64'(m_pbd));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("detect_count", 64'(detect_count), m_cnt);
    if (out_valid === 1'b1) begin
      g.cyc = cyc; g.p = longint'(p); g.pd = pattern_detect;
      g.pbd = pattern_b_detect; g.ovf = overflow; g.cnt = longint'(detect_count);
      got.push_back(g);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int aa, input int bb);
    opmode   = op;
    a        = AW'(aa);
    b        = BW'(bb);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    m_p = 0; m_pd = 0; m_pbd = 0; m_ovf = 0; m_ov = 0; m_cnt = 0;
    rst = 1'b1; in_valid = 1'b1; a = AW'(3); b = BW'(3); opmode = 2'b00;
    pattern = '0; mask = '0;

    // Reset, with in_valid held high to show it is ignored.
    repeat (2) tick();
    rst = 1'b0; in_valid = 1'b0;
    repeat (4) tick();
    check("rst_p", 64'(p), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_pd", 64'(pattern_detect), 0);
    check("rst_cnt", 64'(detect_count), 0);

    // MUL 12x2 against pattern 24, then 12x3.
    pattern = 24; mask = '0;
    issue(2'b00, 12, 2);
    repeat (3) tick();
    check("mul1_valid", 64'(out_valid), 1);
    check("mul1_p", 64'(p), 24);
    check("mul1_pd", 64'(pattern_detect), 1);
    check("mul1_cnt", 64'(detect_count), 1);
    issue(2'b00, 12, 3);
    repeat (3) tick();
    check("mul2_p", 64'(p), 36);
    check("mul2_pd", 64'(pattern_detect), 0);

    // CLR then five back-to-back ACC 12x3.
    got.delete();
    issue(2'b10, 0, 0);
    for (int i = 0; i < 5; i++) issue(2'b01, 12, 3);
    repeat (4) tick();
    check("acc_count", 64'(got.size()), 6);
    for (int i = 1; i <= 5; i++) begin
      check("acc_p", 64'(got[i].p), 64'(36 * i));
      check("acc_cyc", 64'(got[i].cyc - got[1].cyc), 64'(i - 1));
      check("acc_ovf", 64'(got[i].ovf), 0);
    end

    // CLR, five ACC 2047x2047 (carry-out on the fifth), HOLD, CLR.
    got.delete();
    issue(2'b10, 0, 0);
    for (int i = 0; i < 5; i++) issue(2'b01, 2047, 2047);
    issue(2'b11, 0, 0);
    issue(2'b10, 0, 0);
    repeat (4) tick();
    check("big_count", 64'(got.size()), 8);
    check("big4_p", 64'(got[4].p), 16760836);
    check("big4_ovf", 64'(got[4].ovf), 0);
    check("big5_p", 64'(got[5].p), 4173829);
    check("big5_ovf", 64'(got[5].ovf), 1);
    check("hold_ovf", 64'(got[6].ovf), 1);
    check("hold_p", 64'(got[6].p), 4173829);
    check("clr_ovf", 64'(got[7].ovf), 0);
    check("clr_p", 64'(got[7].p), 0);

    // Detect on running sum 72; third ACC depends on the autoreset build.
    got.delete();
    pattern = 72; mask = '0;
    issue(2'b10, 0, 0);
    for (int i = 0; i < 3; i++) issue(2'b01, 12, 3);
    repeat (4) tick();
    check("ar_count", 64'(got.size()), 4);
    check("ar_p1", 64'(got[1].p), 36);
    check("ar_p2", 64'(got[2].p), 72);
    check("ar_pd2", 64'(got[2].pd), 1);
    check("ar_p3", 64'(got[3].p), EXP_THIRD);

    // Low nibble compare only.
    pattern = '0; mask = 24'hFFFFF0;
    issue(2'b00, 12, 4);
    repeat (3) tick();
    check("mask_p", 64'(p), 48);
    check("mask_pd", 64'(pattern_detect), 1);
    issue(2'b00, 15, 1);
    repeat (3) tick();
    check("mask_pbd", 64'(pattern_b_detect), 1);
    check("mask_pd_off", 64'(pattern_detect), 0);

    // All-ones mask: both detects fire.
    mask = '1;
    issue(2'b00, 100, 100);
    repeat (3) tick();
    check("allmask_pd", 64'(pattern_detect), 1);
    check("allmask_pbd", 64'(pattern_b_detect), 1);

    // Counter to 254, then overflow and saturation on the same result.
    got.delete();
    mask = '1;
    issue(2'b10, 0, 0);
    for (int i = 0; i < 253; i++) issue(2'b11, 0, 0);
    repeat (3) tick();
    mask = '0; pattern = 24'd4173829;
    for (int i = 0; i < 5; i++) issue(2'b01, 2047, 2047);
    issue(2'b11, 0, 0);
    repeat (4) tick();
    check("sat_count", 64'(got.size()), 260);
    check("sat_pre_cnt", 64'(got[253].cnt), 254);
    check("sat_acc4_ovf", 64'(got[257].ovf), 0);
    check("sat_acc5_p", 64'(got[258].p), 4173829);
    check("sat_acc5_ovf", 64'(got[258].ovf), 1);
    check("sat_acc5_cnt", 64'(got[258].cnt), 255);
    check("sat_hold_cnt", 64'(got[259].cnt), 255);
    check("sat_hold_ovf", 64'(got[259].ovf), 1);

    // Reset one cycle after three MULs: nothing emerges.
    got.delete();
    issue(2'b00, 7, 9);
    issue(2'b00, 3, 3);
    issue(2'b00, 2, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rstmid_pulses", 64'(got.size()), 0);
    check("rstmid_p", 64'(p), 0);
    check("rstmid_pd", 64'(pattern_detect), 0);
    check("rstmid_ovf", 64'(overflow), 0);
    check("rstmid_cnt", 64'(detect_count), 0);
    issue(2'b00, 5, 5);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check("post_rst_latency", 64'(lat), 3);
    check("post_rst_p", 64'(p), 25);

    // Randomized traffic including occasional resets.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      opmode   = 2'($urandom);
      a        = AW'($urandom);
      b        = BW'($urandom);
      pattern  = ($urandom_range(0, 1) == 1) ? PW'($urandom) : PW'($urandom_range(0, 64));
      case ($urandom_range(0, 2))
        0:       mask = '0;
        1:       mask = PW'($urandom) | 24'hFFFF00;
        default: mask = '1;
      endcase
      rst = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_pattern_detect.md
# mac_pattern_detect

Parametrised, pipelined multiply/accumulate unit with masked pattern and inverse-pattern detection, a sticky overflow flag and a saturating detect counter. It generalises the fixed-width registered multiplier with pattern detection: it adds configurable operand and result widths, runtime opmodes, a valid handshake, and accumulation feedback. It sits in the DSP datapath wherever a product or running sum must be compared against a runtime pattern, for example terminal-count or threshold detection.

## Interface
- `A_WIDTH`, default 11: width of operand `a`, unsigned.
- `B_WIDTH`, default 11: width of operand `b`, unsigned.
- `P_WIDTH`, default 24: width of the result. Must be at least `A_WIDTH+B_WIDTH`.
- `CNT_WIDTH`, default 8: width of the detect counter.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: qualifies `a`, `b` and `opmode` in the current cycle.
- `a`  in  A_WIDTH: multiplicand.
- `b`  in  B_WIDTH: multiplier.
- `opmode`  in  2: operation select. 00 = MUL, 01 = ACC, 10 = CLR, 11 = HOLD.
- `pattern`  in  P_WIDTH: compare pattern. Sampled at stage 3.
- `mask`  in  P_WIDTH: compare mask. A bit value of 1 means that bit is ignored. Sampled at stage 3.
- `out_valid`  out  1: one-cycle pulse per accepted input.
- `p`  out  P_WIDTH: result register.
- `pattern_detect`  out  1: `(p & ~mask) == (pattern & ~mask)`.
- `pattern_b_detect`  out  1: `(p & ~mask) == (~pattern & ~mask)`.
- `overflow`  out  1: sticky flag, set when an ACC carry-out occurs.
- `detect_count`  out  CNT_WIDTH: saturating count of `out_valid` cycles with `pattern_detect` = 1.

## Operation
- Three-stage pipeline. Each stage carries a valid bit, and there is no backpressure.
  - S1 registers `a`, `b` and `opmode` when `in_valid` = 1.
  - S2 registers the product `M = a*b`, zero-extended to P_WIDTH.
  - S3 updates `p` and the flags, and pulses `out_valid`.
- S3 operation by opmode, applied only when the S2 valid bit = 1:
  - MUL: `p <= M`.
  - ACC: `p <= p + M`. The result is modulo 2^P_WIDTH. A carry-out sets `overflow`.
  - CLR: `p <= 0`. Also clears `overflow` and `detect_count`.
  - HOLD: `p` is unchanged.
- `pattern_detect` and `pattern_b_detect` are computed from the next value of `p`, using the `pattern` and `mask` sampled in the S3 cycle. They are registered alongside `p`, so they are always aligned with it.
- With S2 invalid: `p`, `pattern_detect`, `pattern_b_detect`, `overflow` and `detect_count` hold their values, and `out_valid` = 0.
- `detect_count` increments by 1 on each S3 update that yields `pattern_detect` = 1. It saturates at 2^CNT_WIDTH−1.
  - On a CLR, the count is set to 0. If the comparison of 0 against `pattern`/`mask` detects, the count is set to 1 instead.
- Back-to-back ACC operations use the just-updated `p` with no bubble: the feedback path is S3 to S3.

## Timing
- Latency: input accepted on edge n produces `p` and `out_valid` on edge n+3.
- Throughput: one operation per cycle.
- Reset values:
  - `out_valid` = 0, `p` = 0, `pattern_detect` = 0, `pattern_b_detect` = 0, `overflow` = 0, `detect_count` = 0.
  - All stage valid bits = 0.
- Reset mid-operation: all in-flight operations are discarded. No `out_valid` pulse is produced for inputs accepted before `rst`.
- `in_valid` is ignored in any cycle where `rst` = 1.
- Simultaneous overflow and saturation: both flags update in the same cycle. Overflow stays sticky until CLR or `rst`.
- `mask` all ones: `pattern_detect` = 1 and `pattern_b_detect` = 1 on every update.

## Configuration
- `MAC_PD_AUTORESET_EN` defined:
  - If the registered `pattern_detect` = 1, the next S3 ACC uses 0 in place of the `p` feedback, giving `p <= M`. No carry-out is possible on that operation.
  - The rule applies to ACC only. MUL, CLR and HOLD are unaffected.
- `MAC_PD_AUTORESET_EN` undefined: ACC always accumulates onto `p`. The autoreset logic is absent.

## Test plan
- Reset, then MUL with `a`=12, `b`=2, `pattern`=24, `mask`=0 -> 3 cycles later: `out_valid` pulse, `p`=24, `pattern_detect`=1, `detect_count`=1. Then MUL with `a`=12, `b`=3 -> `p`=36, `pattern_detect`=0.
- CLR, then five back-to-back ACC with `a`=12, `b`=3 -> `p` = 36, 72, 108, 144, 180 on consecutive cycles, with five `out_valid` pulses and `overflow`=0.
- CLR, then five ACC with `a`=`b`=2047 (P_WIDTH=24):
  - -> 4th result `p`=16760836 with `overflow`=0.
  - -> 5th result `p`=4173829 with `overflow`=1.
  - -> `overflow` stays 1 through a HOLD and is cleared by CLR.
- `pattern`=72, `mask`=0, CLR, then ACC 12×3 three times -> `p` = 36, 72 (detect), then 36 with `MAC_PD_AUTORESET_EN` defined, or 108 without it.
- `mask`=0xFFFFF0, `pattern`=0, MUL with `a`=12, `b`=4 -> `p`=48, `pattern_detect`=1. Then MUL with `a`=15, `b`=1 -> `pattern_b_detect`=1.
- Issue three MULs, assert `rst` one cycle after the third -> no `out_valid` pulses and all outputs 0. A new MUL with `a`=5, `b`=5 after `rst` -> `p`=25 with latency 3.
